// File: rtl/audio_pkg.sv
// Shared types and timing constants for the audio capture path.
// Holds the recorder state encoding, SRAM write-cycle lengths and I2S framing constants.
package audio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SHIFT,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } rec_state_e;

    localparam int unsigned WR_SETUP_CYC = 1;
    localparam int unsigned WR_PULSE_CYC = 2;
    localparam int unsigned WR_HOLD_CYC  = 1;

    localparam int unsigned SAMPLE_BITS  = 16;
    localparam int unsigned SKIP_BITS    = 1;

    function automatic logic is_write_state(input rec_state_e s);
        return (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
    endfunction

endpackage

// File: rtl/audio_recorder_adc.sv
// WM8731 ADC left-channel deserializer: synchronizes the codec pins onto clk,
// detects BCLK rises / ADCLRCK falls and shifts in one MSB-first sample per frame.
module adc_deserializer
    import audio_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bclk,
    input  logic              adclrck,
    input  logic              adcdat,
    output logic              frame_start,
    output logic              sample_valid,
    output logic [DATA_W-1:0] sample
);

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   bclk_prev;
    logic                   lrck_prev;
    logic                   bclk_rise;
    logic                   lrck_fall;
    logic                   dat_bit;
    logic                   armed;
    logic [1:0]             skip_cnt;
    logic [4:0]             bit_cnt;
    logic [DATA_W-1:0]      shift_q;
    logic                   take_bit;

    // Edge pulses are registered so a pin edge appears SYNC_STAGES+1 cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
            lrck_prev <= 1'b0;
            bclk_rise <= 1'b0;
            lrck_fall <= 1'b0;
            dat_bit   <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], adclrck};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], adcdat};
            bclk_prev <= bclk_sync[SYNC_STAGES-1];
            lrck_prev <= lrck_sync[SYNC_STAGES-1];
            bclk_rise <= bclk_sync[SYNC_STAGES-1] & ~bclk_prev;
            lrck_fall <= ~lrck_sync[SYNC_STAGES-1] & lrck_prev;
            dat_bit   <= dat_sync[SYNC_STAGES-1];
        end
    end

    // sample/sample_valid is a one-cycle strobe with no backpressure: the
    // consumer takes it in the valid cycle or loses it. frame_start likewise.
    assign take_bit     = bclk_rise && armed && (skip_cnt == 2'd0);
    assign sample_valid = take_bit && (bit_cnt == 5'(SAMPLE_BITS - 1));
    assign sample       = {shift_q[DATA_W-2:0], dat_bit};
    assign frame_start  = lrck_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            skip_cnt <= 2'd0;
            bit_cnt  <= 5'd0;
            shift_q  <= '0;
        end else if (lrck_fall) begin
            armed    <= 1'b1;
            skip_cnt <= 2'(SKIP_BITS);
            bit_cnt  <= 5'd0;
        end else if (bclk_rise && armed) begin
            if (skip_cnt != 2'd0) begin
                skip_cnt <= skip_cnt - 2'd1;
            end else begin
                shift_q <= sample;
                bit_cnt <= bit_cnt + 5'd1;
                if (sample_valid) begin
                    armed <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/audio_recorder.sv
// Recorder control: writes each captured left-channel sample to consecutive
// SRAM words from address 0 and reports the end address to playback.
module audio_recorder
    import audio_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK50,
    input  logic              RESET_N,
    input  logic              REC_EN,
    input  logic              PAUSE,
    input  logic              STOP,
    input  logic              BCLK,
    input  logic              ADCLRCK,
    input  logic              ADCDAT,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [DATA_W-1:0] SRAM_DQ_OUT,
    output logic              SRAM_DQ_OE,
    output logic              SRAM_WE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic [ADDR_W-1:0] END_ADDR,
    output logic              BUSY,
    output logic              FULL,
    output rec_state_e        dbg_state
);

    rec_state_e        state, state_n;
    logic [1:0]        wait_cnt;
    logic              rec_en_d;
    logic              stop_pend;
    logic              rec_start;
    logic              end_req;
    logic              phase_last;
    logic              frame_start;
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] end_addr_q;
    logic [DATA_W-1:0] data_q;
    logic              we_n_q;
    logic              dq_oe_q;
    logic              busy_q;
    logic              full_q;

    adc_deserializer #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_adc (
        .clk          (CLK50),
        .rst_n        (RESET_N),
        .bclk         (BCLK),
        .adclrck      (ADCLRCK),
        .adcdat       (ADCDAT),
        .frame_start  (frame_start),
        .sample_valid (sample_valid),
        .sample       (sample)
    );

    assign rec_start = REC_EN & ~rec_en_d;
    assign end_req   = STOP | ~REC_EN;

    always_comb begin
        state_n    = state;
        phase_last = 1'b0;
        case (state)
            IDLE:     if (rec_start) state_n = ARM;
            ARM: begin
                if (end_req)                    state_n = DONE;
                else if (frame_start && !PAUSE) state_n = SHIFT;
            end
            SHIFT: begin
                if (end_req)           state_n = DONE;
                else if (sample_valid) state_n = WR_SETUP;
            end
            WR_SETUP: begin
                phase_last = (wait_cnt == 2'(WR_SETUP_CYC - 1));
                if (phase_last) state_n = WR_PULSE;
            end
            WR_PULSE: begin
                phase_last = (wait_cnt == 2'(WR_PULSE_CYC - 1));
                if (phase_last) state_n = WR_HOLD;
            end
            WR_HOLD: begin
                // A stop seen anywhere in the write cycle takes effect only here.
                phase_last = (wait_cnt == 2'(WR_HOLD_CYC - 1));
                if (phase_last)
                    state_n = (addr_q == '1 || stop_pend || end_req) ? DONE : ARM;
            end
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            wait_cnt   <= 2'd0;
            rec_en_d   <= 1'b0;
            stop_pend  <= 1'b0;
            addr_q     <= '0;
            end_addr_q <= '0;
            data_q     <= '0;
            we_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state     <= state_n;
            rec_en_d  <= REC_EN;
            wait_cnt  <= (state_n == state) ? wait_cnt + 2'd1 : 2'd0;
            we_n_q    <= (state_n != WR_PULSE);
            dq_oe_q   <= is_write_state(state_n);
            busy_q    <= (state_n != IDLE);
            stop_pend <= is_write_state(state_n) && (stop_pend || end_req);
            if (state == IDLE && rec_start) begin
                addr_q     <= '0;
                end_addr_q <= '0;
                full_q     <= 1'b0;
            end
            if (state == SHIFT && state_n == WR_SETUP) begin
                data_q <= sample;
            end
            if (state == WR_HOLD && phase_last) begin
                addr_q     <= addr_q + ADDR_W'(1);
                end_addr_q <= addr_q + ADDR_W'(1);
                if (addr_q == '1) full_q <= 1'b1;
            end
        end
    end

    assign SRAM_ADDR   = addr_q;
    assign SRAM_DQ_OUT = data_q;
    assign SRAM_DQ_OE  = dq_oe_q;
    assign SRAM_WE_N   = we_n_q;
    assign SRAM_CE_N   = ~busy_q;
    assign SRAM_OE_N   = 1'b1;
    assign SRAM_UB_N   = ~busy_q;
    assign SRAM_LB_N   = ~busy_q;
    assign END_ADDR    = end_addr_q;
    assign BUSY        = busy_q;
    assign FULL        = full_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_audio_recorder.sv
// Bench for audio_recorder: I2S frame driver, write scoreboard per DUT and
// directed scenarios; a 1-bit-address instance exercises the memory-full path.
module tb_audio_recorder;
    import audio_pkg::*;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int AW_F   = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rec_en = 1'b0, pause = 1'b0, stop = 1'b0;
    logic bclk = 1'b1, adclrck = 1'b1, adcdat = 1'b0;

    logic [ADDR_W-1:0] sram_addr, end_addr;
    logic [DATA_W-1:0] sram_dq_out;
    logic sram_dq_oe, sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n, busy, full;
    rec_state_e dbg_state;

    logic [AW_F-1:0] sram_addr_f, end_addr_f;
    logic [DATA_W-1:0] sram_dq_out_f;
    logic sram_dq_oe_f, sram_we_n_f, sram_ce_n_f, sram_oe_n_f, sram_ub_n_f, sram_lb_n_f, busy_f, full_f;
    rec_state_e dbg_state_f;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [AW_F+DATA_W-1:0] exp_f_q[$];
    bit mon_en = 1'b1;
    bit mon_f_en = 1'b0;

    // ---------------- clock / reset ----------------
    always #10 clk = ~clk;

    audio_recorder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .CLK50(clk), .RESET_N(rst_n), .REC_EN(rec_en), .PAUSE(pause), .STOP(stop),
        .BCLK(bclk), .ADCLRCK(adclrck), .ADCDAT(adcdat),
        .SRAM_ADDR(sram_addr), .SRAM_DQ_OUT(sram_dq_out), .SRAM_DQ_OE(sram_dq_oe),
        .SRAM_WE_N(sram_we_n), .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n),
        .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n), .END_ADDR(end_addr),
        .BUSY(busy), .FULL(full), .dbg_state(dbg_state)
    );

    audio_recorder #(.ADDR_W(AW_F), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut_f (
        .CLK50(clk), .RESET_N(rst_n), .REC_EN(rec_en), .PAUSE(pause), .STOP(stop),
        .BCLK(bclk), .ADCLRCK(adclrck), .ADCDAT(adcdat),
        .SRAM_ADDR(sram_addr_f), .SRAM_DQ_OUT(sram_dq_out_f), .SRAM_DQ_OE(sram_dq_oe_f),
        .SRAM_WE_N(sram_we_n_f), .SRAM_CE_N(sram_ce_n_f), .SRAM_OE_N(sram_oe_n_f),
        .SRAM_UB_N(sram_ub_n_f), .SRAM_LB_N(sram_lb_n_f), .END_ADDR(end_addr_f),
        .BUSY(busy_f), .FULL(full_f), .dbg_state(dbg_state_f)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboards ----------------
    logic we_prev = 1'b1, we_prev_f = 1'b1;
    int low_cnt = 0, low_cnt_f = 0;
    logic [ADDR_W+DATA_W-1:0] cur_m;
    logic [AW_F+DATA_W-1:0] cur_f;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!sram_we_n && we_prev) begin
                low_cnt = 1;
                check("wr_dq_oe", sram_dq_oe, 1);
                check("wr_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur_m = exp_q.pop_front();
                    check("wr_addr", sram_addr, cur_m[ADDR_W+DATA_W-1:DATA_W]);
                    check("wr_data", sram_dq_out, cur_m[DATA_W-1:0]);
                end
            end else if (!sram_we_n) begin
                low_cnt++;
            end else if (!we_prev) begin
                check("we_pulse_len", low_cnt, 2);
                check("hold_addr", sram_addr, cur_m[ADDR_W+DATA_W-1:DATA_W]);
                check("hold_data", sram_dq_out, cur_m[DATA_W-1:0]);
            end
        end
        we_prev = sram_we_n;
    end

    always @(negedge clk) begin
        if (mon_f_en) begin
            if (!sram_we_n_f && we_prev_f) begin
                low_cnt_f = 1;
                check("f_wr_pending", exp_f_q.size() != 0, 1);
                if (exp_f_q.size() != 0) begin
                    cur_f = exp_f_q.pop_front();
                    check("f_wr_addr", sram_addr_f, cur_f[AW_F+DATA_W-1:DATA_W]);
                    check("f_wr_data", sram_dq_out_f, cur_f[DATA_W-1:0]);
                end
            end else if (!sram_we_n_f) begin
                low_cnt_f++;
            end else if (!we_prev_f) begin
                check("f_we_pulse_len", low_cnt_f, 2);
            end
        end
        we_prev_f = sram_we_n_f;
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One BCLK period per b: data changes with BCLK low, sampled on the rise.
    task automatic i2s_bits(input logic lr, input logic [15:0] word, input int first, input int last);
        for (int b = first; b < last; b++) begin
            bclk = 1'b0;
            if (b == 0) adclrck = lr;
            adcdat = (b >= 1 && b <= 16) ? word[16 - b] : 1'($urandom_range(0, 1));
            #100;
            bclk = 1'b1;
            #100;
        end
    endtask

    task automatic i2s_frame(input logic [15:0] left, input logic [15:0] right);
        i2s_bits(1'b0, left, 0, 20);
        i2s_bits(1'b1, right, 0, 20);
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic restart();
        @(negedge clk);
        rec_en = 1'b0;
        cycles(6);
        rec_en = 1'b1;
        cycles(3);
    endtask

    task automatic wait_we(input logic level, input string tag);
        int n;
        n = 0;
        while (sram_we_n !== level && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, sram_we_n, level);
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] v [0:2];
    logic [15:0] w;

    initial begin
        cycles(3);
        check("rst_addr", sram_addr, 0);
        check("rst_dq", sram_dq_out, 0);
        check("rst_end", end_addr, 0);
        check("rst_dq_oe", sram_dq_oe, 0);
        check("rst_strobes", {sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}, 5'b11111);
        check("rst_busy_full", {busy, full}, 2'b00);
        check("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;
        cycles(5);

        // Single frame; STOP in the same cycle as the start is ignored.
        rec_en = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        cycles(2);
        check("start_busy", busy, 1);
        check("start_strobes", {sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}, 4'b0100);
        check("start_state", dbg_state, ARM);
        expect_write(0, 16'hA5C3);
        i2s_frame(16'hA5C3, 16'($urandom_range(0, 65535)));
        cycles(2);
        check("single_end", end_addr, 1);
        check("single_busy", busy, 1);

        // Leaving recording holds END_ADDR; new recording clears it.
        rec_en = 1'b0;
        cycles(4);
        check("off_busy", busy, 0);
        check("off_end_hold", end_addr, 1);
        rec_en = 1'b1;
        cycles(3);
        check("restart_end_clr", end_addr, 0);

        // Right-channel isolation.
        for (int i = 0; i < 3; i++) begin
            expect_write(ADDR_W'(i), 16'h1234);
            i2s_frame(16'h1234, 16'hFFFF);
        end
        cycles(2);
        check("iso_end", end_addr, 3);
        check("iso_drained", exp_q.size(), 0);

        // Pause between samples 2 and 3.
        restart();
        for (int i = 0; i < 3; i++) v[i] = 16'($urandom_range(0, 65535));
        for (int i = 0; i < 2; i++) begin
            expect_write(ADDR_W'(i), v[i]);
            i2s_frame(v[i], 16'($urandom_range(0, 65535)));
        end
        @(negedge clk);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) i2s_frame(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        @(negedge clk);
        check("pause_end", end_addr, 2);
        pause = 1'b0;
        expect_write(2, v[2]);
        i2s_frame(v[2], 16'($urandom_range(0, 65535)));
        cycles(2);
        check("pause_after_end", end_addr, 3);

        // STOP mid-SHIFT: no write, END_ADDR unchanged.
        restart();
        w = 16'($urandom_range(0, 65535));
        expect_write(0, w);
        i2s_frame(w, 16'h0F0F);
        w = 16'($urandom_range(0, 65535));
        i2s_bits(1'b0, w, 0, 9);
        @(negedge clk);
        check("shift_state", dbg_state, SHIFT);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_shift_busy1", busy, 1);
        @(negedge clk);
        check("stop_shift_busy0", busy, 0);
        check("stop_shift_state", dbg_state, IDLE);
        i2s_bits(1'b0, w, 9, 20);
        i2s_bits(1'b1, 16'hFFFF, 0, 20);
        check("stop_shift_end", end_addr, 1);
        check("stop_shift_nowr", exp_q.size(), 0);

        // STOP during WR_PULSE: write completes, END_ADDR increments.
        restart();
        w = 16'($urandom_range(0, 65535));
        expect_write(0, w);
        fork
            i2s_frame(w, 16'h5555);
            begin
                wait_we(1'b0, "stop_wr_we_low");
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
                wait_we(1'b1, "stop_wr_we_high");
                check("stop_wr_busy_hold", busy, 1);
                @(negedge clk);
                check("stop_wr_busy_done", busy, 1);
                @(negedge clk);
                check("stop_wr_busy0", busy, 0);
            end
        join
        check("stop_wr_end", end_addr, 1);

        // Memory full, on a 1-bit-address instance: last two words, then wrap.
        mon_f_en = 1'b1;
        restart();
        check("full_clr", full_f, 0);
        for (int i = 0; i < 3; i++) begin
            v[i] = 16'($urandom_range(0, 65535));
            expect_write(ADDR_W'(i), v[i]);
        end
        exp_f_q.push_back({1'b0, v[0]});
        exp_f_q.push_back({1'b1, v[1]});
        i2s_frame(v[0], 16'hFFFF);
        check("full_f_end1", end_addr_f, 1);
        check("full_f_notfull", full_f, 0);
        i2s_frame(v[1], 16'hFFFF);
        check("full_f_full", full_f, 1);
        check("full_f_end_wrap", end_addr_f, 0);
        check("full_f_busy", busy_f, 0);
        i2s_frame(v[2], 16'hFFFF);
        check("full_f_drained", exp_f_q.size(), 0);
        check("full_f_stays", full_f, 1);
        check("full_main_end", end_addr, 3);
        check("full_main_notfull", full, 0);
        mon_f_en = 1'b0;

        // Reset mid-write releases WE_N without a clock edge.
        restart();
        w = 16'($urandom_range(1, 65535));
        expect_write(0, w);
        i2s_frame(w, 16'h0000);
        mon_en = 1'b0;
        w = 16'($urandom_range(1, 65535));
        fork
            i2s_frame(w, 16'h0000);
            begin
                wait_we(1'b0, "rst_wr_we_low");
                check("rst_pre_addr", sram_addr, 1);
                #3;
                rst_n = 1'b0;
                rec_en = 1'b0;
                #1;
                check("rst_async_we", sram_we_n, 1);
                check("rst_async_dq_oe", sram_dq_oe, 0);
                check("rst_async_addr", sram_addr, 0);
                check("rst_async_dq", sram_dq_out, 0);
                check("rst_async_end", end_addr, 0);
                check("rst_async_busy", {busy, full, sram_ce_n, sram_ub_n, sram_lb_n}, 5'b00111);
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        cycles(4);
        check("post_rst_state", dbg_state, IDLE);
        check("post_rst_we", sram_we_n, 1);
        check("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
